pio_mem_rd_arb: RTL and testbench
=================================

Name: pio_mem_rd_arb

Overview:
- Round-robin arbiter that shares the single application read port of a PIO-accessible write-only memory between NUM_REQ application requesters.
- Issues at most one read per cycle toward the memory and tracks in-flight reads in a small requester-ID FIFO.
- Steers each returned word and a one-cycle ack back to the requester that issued it.
- Sits between per-engine lookup clients and the memory's app_mem_rd/app_mem_raddr/app_mem_ack/app_mem_rdata interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REQ_NBITS, 2, ceil(log2(NUM_REQ)), width of a requester ID.
- WIDTH, 20, memory data width.
- DEPTH_NBITS, 1, memory address width.
- FIFO_NBITS, 2, log2 of in-flight ID FIFO depth (depth 4 covers the memory's fixed 3-cycle read latency plus 1).

Ports:
- clk  in  1  single block clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  NUM_REQ  per-requester read request, level, held until granted.
- req_addr  in  NUM_REQ*DEPTH_NBITS  packed per-requester read address; slice i belongs to requester i.
- hold  in  1  when 1, no new grant issues this cycle (used by software during table update).
- gnt  out  NUM_REQ  one-hot grant, registered.
- app_mem_rd  out  1  read strobe to memory, registered.
- app_mem_raddr  out  DEPTH_NBITS  read address to memory, registered.
- app_mem_ack  in  1  memory read-data valid.
- app_mem_rdata  in  WIDTH  memory read data.
- rsp_ack  out  NUM_REQ  one-hot response valid, registered.
- rsp_data  out  WIDTH  response data, registered; shared by all requesters.
- err_unexp_ack  out  1  sticky; set when app_mem_ack arrives with the ID FIFO empty.

Behaviour:
- Reset values:
  - gnt, app_mem_rd, rsp_ack, err_unexp_ack = 0.
  - app_mem_raddr, rsp_data = 0.
  - Round-robin pointer = 0; ID FIFO empty.
- Issue condition, evaluated each cycle:
  - Requires |req, ~hold and FIFO not full.
  - "Not full" is counted including an issue already registered this cycle, so the FIFO never overflows.
- Arbitration:
  - Round-robin starting at last_winner+1 modulo NUM_REQ.
  - After reset the search starts at requester 0.
  - The pointer updates only on an issue.
- Issue cycle N:
  - Winner's bit of gnt is registered to 1 for one cycle.
  - app_mem_rd=1 and app_mem_raddr = req_addr slice of the winner, both at N+1.
  - Winner ID is pushed into the ID FIFO at N+1.
- Requester handshake:
  - A requester sees gnt at N+1 and must drop or update req in that same cycle.
  - The arbiter masks the just-granted requester's req for exactly one cycle after its grant, so a late deassert is not regranted.
- Memory latency: app_mem_ack arrives 3 cycles after app_mem_rd; the block does not rely on this count, only on ordering.
- Return path, on app_mem_ack with FIFO non-empty:
  - Pop the FIFO head.
  - Next cycle: rsp_ack = onehot(head ID), rsp_data = app_mem_rdata.
  - Otherwise rsp_ack = 0 and rsp_data holds.
- Simultaneous push and pop in one cycle: both take effect; occupancy is unchanged.
- Unexpected ack (app_mem_ack with FIFO empty):
  - No pop, no rsp_ack.
  - err_unexp_ack sets and stays set until reset.
- hold asserted: in-flight reads still complete and return; only new issues stop.
- Reset mid-operation: all in-flight reads are discarded; no rsp_ack follows reset release even if the memory later acks. Those late acks set err_unexp_ack (documented, intended).
- Throughput:
  - One grant per cycle sustained while the FIFO has room.
  - With depth 4 and 3-cycle latency there are no stalls under continuous requests.
  - A single requester is granted every other cycle because of the one-cycle mask.
- FIFO pointers wrap modulo 2^FIFO_NBITS. An extra wrap bit distinguishes full from empty.

Decomposition:
- Shared defines (defines.vh): none new. Parameters suffice; the CLK_RST-style async active-low reset macro is reused.
- Sub-module pio_arb_id_fifo:
  - Parameterised width REQ_NBITS and depth 2^FIFO_NBITS.
  - Ports: push, push_data, pop, head, empty, full, count.
  - Flop based, async active-low reset clears pointers.
- Top level contains the round-robin picker, the one-cycle grant mask, the issue registers and the return-steering registers.

Test Plan:
- Single request: req=4'b0010, addr[1]=1 -> gnt=4'b0010 one cycle later; app_mem_rd=1, raddr=1; memory returns 20'hABCDE 3 cycles later -> rsp_ack=4'b0010, rsp_data=20'hABCDE one cycle after app_mem_ack.
- Fairness: all four req held high for 16 cycles -> grant order 0,1,2,3,0,1,... with no requester granted twice before the others; responses arrive in the same order.
- Back-pressure: memory model delays acks to 8 cycles -> at most 4 reads outstanding; gnt stops while the FIFO is full and resumes the cycle after the first pop; no response is lost.
- hold: assert hold with 2 reads in flight -> no new gnt; both in-flight rsp_ack still appear; issuing resumes the cycle after hold drops.
- Unexpected ack: pulse app_mem_ack with nothing issued -> err_unexp_ack=1 and stays 1; rsp_ack stays 0.
- Reset mid-flight: issue 3 reads, assert rst_n=0 for 2 cycles -> gnt, app_mem_rd, rsp_ack = 0 immediately and FIFO empty; after release the first grant goes to requester 0.

Source files
------------

// File: rtl/pio_mem_rd_arb_pkg.sv
// pio_mem_rd_arb_pkg
//   Shared types and helpers for the PIO memory read arbiter.
//   rr_pick() does a round-robin search over a request vector padded to
//   MAX_REQ bits, starting at index 'start' and wrapping modulo 'n'.
package pio_mem_rd_arb_pkg;

  localparam int MAX_REQ       = 8;
  localparam int MAX_REQ_NBITS = 3;

  typedef struct packed {
    logic                     found;
    logic [MAX_REQ_NBITS-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]       req,
                                       input logic [MAX_REQ_NBITS-1:0] start,
                                       input int unsigned              n);
    rr_pick_t    r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (32'(start) + k) % n;
      if (k < n && !r.found && req[idx[MAX_REQ_NBITS-1:0]]) begin
        r.found = 1'b1;
        r.idx   = idx[MAX_REQ_NBITS-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pio_mem_rd_arb_id_fifo.sv
// pio_arb_id_fifo
//   Flop-based FIFO holding the requester ID of every read in flight.
//   Pointers carry one extra wrap bit so full and empty are distinct.
// Ports:
//   clk, rst_n      clock, async active-low reset (clears pointers only)
//   push/push_data  enqueue an ID
//   pop             dequeue the head (caller guarantees non-empty)
//   head            oldest ID
//   empty/full      status
//   count           current occupancy, 0..2^FIFO_NBITS
module pio_arb_id_fifo
  import pio_mem_rd_arb_pkg::*;
#(
  parameter int REQ_NBITS  = 2,
  parameter int FIFO_NBITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [REQ_NBITS-1:0]  push_data,
  input  logic                  pop,
  output logic [REQ_NBITS-1:0]  head,
  output logic                  empty,
  output logic                  full,
  output logic [FIFO_NBITS:0]   count
);

  localparam int DEPTH = 1 << FIFO_NBITS;

  logic [REQ_NBITS-1:0] mem [DEPTH];
  logic [FIFO_NBITS:0]  wr_ptr;
  logic [FIFO_NBITS:0]  rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (FIFO_NBITS+1)'(DEPTH));
  assign head    = mem[rd_ptr[FIFO_NBITS-1:0]];
  // A pop in the same cycle frees the slot, so push is still legal when full.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[FIFO_NBITS-1:0]] <= push_data;
  end

endmodule

// File: rtl/pio_mem_rd_arb.sv
// pio_mem_rd_arb
//   Round-robin arbiter sharing the single application read port of the
//   PIO memory between NUM_REQ requesters. One read issues per cycle at
//   most; the issuing requester's ID is queued and each returned word is
//   steered back with a one-cycle rsp_ack.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   req, req_addr    per-requester level request and packed read address
//   hold             blocks new grants (in-flight reads still return)
//   gnt              registered one-hot grant
//   app_mem_rd/raddr registered read strobe/address to the memory
//   app_mem_ack/rdata memory return
//   rsp_ack/rsp_data registered one-hot response and shared data
//   err_unexp_ack    sticky: ack arrived with no read outstanding
module pio_mem_rd_arb
  import pio_mem_rd_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int REQ_NBITS   = 2,
  parameter int WIDTH       = 20,
  parameter int DEPTH_NBITS = 1,
  parameter int FIFO_NBITS  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DEPTH_NBITS-1:0] req_addr,
  input  logic                           hold,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           app_mem_rd,
  output logic [DEPTH_NBITS-1:0]         app_mem_raddr,
  input  logic                           app_mem_ack,
  input  logic [WIDTH-1:0]               app_mem_rdata,
  output logic [NUM_REQ-1:0]             rsp_ack,
  output logic [WIDTH-1:0]               rsp_data,
  output logic                           err_unexp_ack
);

  localparam int FIFO_DEPTH = 1 << FIFO_NBITS;
  localparam int OCC_W      = FIFO_NBITS + 2;

  logic [NUM_REQ-1:0]     req_eff;
  rr_pick_t               pick;
  logic [REQ_NBITS-1:0]   rr_ptr;
  logic [REQ_NBITS-1:0]   win;
  logic [REQ_NBITS-1:0]   win_q;
  logic [DEPTH_NBITS-1:0] win_addr;
  logic                   issue;
  logic                   room;
  logic                   pop;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [FIFO_NBITS:0]    fifo_count;
  logic [REQ_NBITS-1:0]   fifo_head;
  logic [OCC_W-1:0]       occ_after;

  // The requester granted last cycle may still show req while it reacts to
  // gnt; masking with the live gnt keeps it from being granted twice.
  assign req_eff  = req & ~gnt;
  assign pick     = rr_pick(MAX_REQ'(req_eff), MAX_REQ_NBITS'(rr_ptr), NUM_REQ);
  assign win      = pick.idx[REQ_NBITS-1:0];
  assign win_addr = req_addr[win*DEPTH_NBITS +: DEPTH_NBITS];

  assign pop = app_mem_ack & ~fifo_empty;

  // Occupancy seen by this cycle's issue: queued IDs, plus the read whose
  // strobe is out now (pushed this edge), minus the one being returned.
  assign occ_after = OCC_W'(fifo_count) + OCC_W'(app_mem_rd) - OCC_W'(pop);
  assign room      = fifo_full ? (pop & ~app_mem_rd)
                               : (occ_after < OCC_W'(FIFO_DEPTH));
  assign issue     = pick.found & ~hold & room;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt           <= '0;
      app_mem_rd    <= 1'b0;
      app_mem_raddr <= '0;
      win_q         <= '0;
      rr_ptr        <= '0;
    end else begin
      gnt        <= issue ? (NUM_REQ'(1) << win) : '0;
      app_mem_rd <= issue;
      if (issue) begin
        app_mem_raddr <= win_addr;
        win_q         <= win;
        rr_ptr        <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ack       <= '0;
      rsp_data      <= '0;
      err_unexp_ack <= 1'b0;
    end else begin
      rsp_ack <= pop ? (NUM_REQ'(1) << fifo_head) : '0;
      if (pop) rsp_data <= app_mem_rdata;
      if (app_mem_ack && fifo_empty) err_unexp_ack <= 1'b1;
    end
  end

  pio_arb_id_fifo #(
    .REQ_NBITS (REQ_NBITS),
    .FIFO_NBITS(FIFO_NBITS)
  ) u_id_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (app_mem_rd),
    .push_data(win_q),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_pio_mem_rd_arb.sv
// tb_pio_mem_rd_arb
//   Randomised and directed stimulus against a queue-based reference model
//   of the arbiter. Inputs are driven and outputs compared on the falling
//   edge; the memory responder returns each read a fixed number of cycles
//   after its strobe.
module tb_pio_mem_rd_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req_addr;
  logic        hold;
  logic [3:0]  gnt;
  logic        app_mem_rd;
  logic [0:0]  app_mem_raddr;
  logic        app_mem_ack;
  logic [19:0] app_mem_rdata;
  logic [3:0]  rsp_ack;
  logic [19:0] rsp_data;
  logic        err_unexp_ack;

  always #5 clk = ~clk;

  pio_mem_rd_arb #(
    .NUM_REQ(4), .REQ_NBITS(2), .WIDTH(20), .DEPTH_NBITS(1), .FIFO_NBITS(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_addr     (req_addr),
    .hold         (hold),
    .gnt          (gnt),
    .app_mem_rd   (app_mem_rd),
    .app_mem_raddr(app_mem_raddr),
    .app_mem_ack  (app_mem_ack),
    .app_mem_rdata(app_mem_rdata),
    .rsp_ack      (rsp_ack),
    .rsp_data     (rsp_data),
    .err_unexp_ack(err_unexp_ack)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_rd   = 0;
  int n_rsp  = 0;

  // stimulus controls
  logic [3:0] pending   = '0;
  logic [3:0] persist   = '0;
  logic [3:0] addr_cmd  = '0;
  logic       hold_cmd  = 1'b0;
  logic       force_ack = 1'b0;
  logic       mem_fixed = 1'b0;
  logic       rand_req  = 1'b0;
  logic       rand_hold = 1'b0;
  logic       rst_go    = 1'b0;
  int         rst_cnt   = 0;
  int         mem_lat   = 3;
  int         mq[$];

  // reference model: outputs expected in the coming cycle
  logic [3:0]  exp_gnt, exp_rsp_ack;
  logic        exp_rd, exp_raddr, exp_err;
  logic [19:0] exp_rsp_data;
  int          q[$];   // IDs issued and not yet returned, oldest first
  int          ptr;    // first requester searched on the next issue

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_gnt = '0; exp_rsp_ack = '0; exp_rd = 1'b0; exp_raddr = 1'b0;
    exp_err = 1'b0; exp_rsp_data = '0; q.delete(); ptr = 0;
  endtask

  task automatic model_update();
    logic [3:0] eligible;
    logic       pop, issue;
    int         win, idx;
    if (!rst_n) begin
      model_clear();
      return;
    end
    eligible = req & ~exp_gnt;
    pop      = app_mem_ack && (q.size() > 0);
    if (app_mem_ack && q.size() == 0) exp_err = 1'b1;
    issue = 1'b0;
    win   = 0;
    if (!hold && (q.size() - int'(pop)) < 4) begin
      for (int k = 0; k < 4; k++) begin
        idx = (ptr + k) % 4;
        if (!issue && eligible[idx]) begin
          issue = 1'b1;
          win   = idx;
        end
      end
    end
    if (pop) begin
      exp_rsp_ack  = 4'(1 << q.pop_front());
      exp_rsp_data = app_mem_rdata;
    end else begin
      exp_rsp_ack = '0;
    end
    exp_gnt = issue ? 4'(1 << win) : 4'b0;
    exp_rd  = issue;
    if (issue) begin
      exp_raddr = req_addr[win];
      q.push_back(win);
      ptr = (win + 1) % 4;
    end
  endtask

  task automatic step();
    logic ack;
    @(negedge clk);
    cyc++;
    chk("gnt",           32'(gnt),           32'(exp_gnt));
    chk("app_mem_rd",    32'(app_mem_rd),    32'(exp_rd));
    chk("app_mem_raddr", 32'(app_mem_raddr), 32'(exp_raddr));
    chk("rsp_ack",       32'(rsp_ack),       32'(exp_rsp_ack));
    chk("rsp_data",      32'(rsp_data),      32'(exp_rsp_data));
    chk("err_unexp_ack", 32'(err_unexp_ack), 32'(exp_err));
    if (app_mem_rd) n_rd++;
    if (rsp_ack != 0) n_rsp++;

    if (rst_go) begin
      rst_n = 1'b0; rst_go = 1'b0; rst_cnt = 2; pending = '0;
    end else if (rst_cnt > 0) begin
      rst_cnt--;
      if (rst_cnt == 0) rst_n = 1'b1;
    end

    for (int i = 0; i < 4; i++)
      if (gnt[i] && !persist[i]) pending[i] = 1'b0;
    if (rand_req)
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 2) == 0) pending[i] = 1'b1;
    req      = pending;
    req_addr = rand_req ? 4'($urandom) : addr_cmd;
    hold     = rand_hold ? ($urandom_range(0, 7) == 0) : hold_cmd;

    if (app_mem_rd) mq.push_back(cyc + mem_lat);
    ack = 1'b0;
    if (mq.size() > 0 && mq[0] == cyc) begin
      ack = 1'b1;
      void'(mq.pop_front());
    end
    app_mem_ack   = ack | force_ack;
    app_mem_rdata = mem_fixed ? 20'hABCDE : 20'($urandom);

    model_update();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((mq.size() != 0 || q.size() != 0 || pending != 0) && n < 200) begin
      step();
      n++;
    end
    step();
    chk({name, "_drain_in_time"}, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_grants(input int n);
    int g = 0;
    int t = 0;
    while (g < n && t < 20) begin
      step();
      t++;
      if (gnt != 0) g++;
    end
    chk("wait_grants", 32'(g), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, rsp0, outst;
    logic stall_seen;
    rst_n = 1'b0; req = '0; req_addr = '0; hold = 1'b0;
    app_mem_ack = 1'b0; app_mem_rdata = '0;
    model_clear();
    rst_cnt = 3;

    // reset values
    repeat (2) step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rd", 32'(app_mem_rd), 0);
    chk("rst_rsp_ack", 32'(rsp_ack), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_err", 32'(err_unexp_ack), 0);
    repeat (2) step();

    // single request from requester 1, address 1
    pending = 4'b0010; addr_cmd = 4'b0010; mem_fixed = 1'b1;
    step();
    step();
    chk("single_gnt", 32'(gnt), 32'h2);
    chk("single_rd", 32'(app_mem_rd), 1);
    chk("single_raddr", 32'(app_mem_raddr), 1);
    repeat (3) step();
    chk("single_no_early_rsp", 32'(rsp_ack), 0);
    step();
    chk("single_rsp_ack", 32'(rsp_ack), 32'h2);
    chk("single_rsp_data", 32'(rsp_data), 32'hABCDE);
    mem_fixed = 1'b0;
    step();
    chk("single_rsp_ack_drop", 32'(rsp_ack), 0);
    chk("single_rsp_data_hold", 32'(rsp_data), 32'hABCDE);
    drain("single");

    // fairness: last winner was 1, so the rotation starts at 2
    persist = 4'hF; pending = 4'hF;
    for (int s = 1; s <= 16; s++) begin
      step();
      if (s >= 2) chk("fair_order", 32'(gnt), 32'(1) << (s % 4));
    end
    persist = '0; pending = '0;
    drain("fair");

    // back-pressure with 8-cycle memory latency
    mem_lat = 8; rd0 = n_rd; rsp0 = n_rsp; stall_seen = 1'b0;
    persist = 4'hF; pending = 4'hF;
    for (int s = 1; s <= 40; s++) begin
      step();
      outst = (n_rd - rd0) - (n_rsp - rsp0);
      chk("bp_outstanding_le4", 32'(outst <= 4), 1);
      if (s > 2 && gnt == 0) stall_seen = 1'b1;
    end
    chk("bp_stall_seen", 32'(stall_seen), 1);
    persist = '0; pending = '0;
    drain("bp");
    chk("bp_no_loss", 32'(n_rsp - rsp0), 32'(n_rd - rd0));
    mem_lat = 3;

    // hold with two reads in flight
    pending = 4'b0101;
    wait_grants(2);
    hold_cmd = 1'b1; pending[1] = 1'b1; persist[1] = 1'b1; rsp0 = n_rsp;
    repeat (10) begin
      step();
      chk("hold_no_gnt", 32'(gnt), 0);
    end
    chk("hold_inflight_rsp", 32'(n_rsp - rsp0), 2);
    hold_cmd = 1'b0;
    step();
    step();
    chk("hold_resume_gnt", 32'(gnt), 32'h2);
    persist = '0;
    drain("hold");

    // unexpected ack
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    step();
    chk("unexp_err", 32'(err_unexp_ack), 1);
    chk("unexp_no_rsp", 32'(rsp_ack), 0);
    repeat (3) step();
    chk("unexp_err_sticky", 32'(err_unexp_ack), 1);

    // reset with three reads in flight
    pending = 4'b0111;
    wait_grants(3);
    rst_go = 1'b1;
    step();
    #1;
    chk("rstmid_gnt", 32'(gnt), 0);
    chk("rstmid_rd", 32'(app_mem_rd), 0);
    chk("rstmid_rsp", 32'(rsp_ack), 0);
    chk("rstmid_err_clr", 32'(err_unexp_ack), 0);
    rsp0 = n_rsp;
    for (int t = 0; t < 20 && mq.size() != 0; t++) step();
    repeat (2) step();
    chk("rstmid_no_rsp", 32'(n_rsp - rsp0), 0);
    chk("rstmid_late_ack_err", 32'(err_unexp_ack), 1);
    pending = 4'hF;
    step();
    step();
    chk("rstmid_first_gnt", 32'(gnt), 32'h1);
    drain("rstmid");

    // random traffic, both latencies
    rand_req = 1'b1; rand_hold = 1'b1;
    repeat (1500) step();
    rand_req = 1'b0; rand_hold = 1'b0;
    drain("rand3");
    mem_lat = 8;
    rand_req = 1'b1; rand_hold = 1'b1;
    repeat (1500) step();
    rand_req = 1'b0; rand_hold = 1'b0;
    drain("rand8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
